mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit output channel between four requesters. It drives the select of an internal `mux4` and registers the chosen word into a valid/ready output stage. It sits between four data producers (for example, debug-unit sources feeding a single UART TX path) and one consumer. It provides one transfer per cycle when the consumer is always ready, and fair rotation under contention.

---
 rtl/mux4_arbiter_pkg.sv | 10 +
 rtl/mux4_arbiter_mux4.sv | 14 +
 rtl/mux4_arbiter.sv | 73 +++++++
 tb/tb_mux4_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arbiter_pkg.sv
// mux4_arbiter_pkg: shared widths, requester count and FSM state encoding
package mux4_arbiter_pkg;
  localparam int NB_DEFAULT        = 32;
  localparam int NB_SELECT_DEFAULT = 2;
  localparam int N_REQ             = 4;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;
endpackage

// File: rtl/mux4_arbiter_mux4.sv
// mux4: 4:1 word multiplexer
//   i_select -> picks i_a/i_b/i_c/i_d onto o_data
module mux4 #(
  parameter int NB = 32
) (
  input  logic [1:0]    i_select,
  input  logic [NB-1:0] i_a,
  input  logic [NB-1:0] i_b,
  input  logic [NB-1:0] i_c,
  input  logic [NB-1:0] i_d,
  output logic [NB-1:0] o_data
);
  always_comb o_data = i_select[1] ? (i_select[0] ? i_d : i_c) : (i_select[0] ? i_b : i_a);
endmodule

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter of four requesters into one registered valid/ready word
//   i_clock, i_reset (async, active-low)
//   i_req, i_a..i_d  -> four requesters; o_grant one-hot accept strobe (combinational)
//   o_data, o_select, o_valid / i_ready -> registered output handshake
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int NB        = NB_DEFAULT,
  parameter int NB_SELECT = NB_SELECT_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [NB-1:0]        i_a,
  input  logic [NB-1:0]        i_b,
  input  logic [NB-1:0]        i_c,
  input  logic [NB-1:0]        i_d,
  input  logic                 i_ready,
  output logic [N_REQ-1:0]     o_grant,
  output logic [NB-1:0]        o_data,
  output logic [NB_SELECT-1:0] o_select,
  output logic                 o_valid
);
  state_e               state_q;
  logic [NB-1:0]        data_q;
  logic [NB-1:0]        mux_out;
  logic [NB_SELECT-1:0] sel_q;
  logic [NB_SELECT-1:0] ptr_q;
  logic [NB_SELECT-1:0] winner;
  logic                 found;
  logic                 take;
  // Scans from lowest to highest priority so the highest-priority hit is written last.
  function automatic logic [NB_SELECT:0] pick(input logic [N_REQ-1:0] req, input logic [NB_SELECT-1:0] ptr);
    logic [NB_SELECT:0]   r;
    logic [NB_SELECT-1:0] k;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + NB_SELECT'(i);
      if (req[k]) r = {1'b1, k};
    end
    return r;
  endfunction
  assign {found, winner} = pick(i_req, ptr_q);
  assign take            = found && (state_q == ST_IDLE || i_ready);
  // Reset gates only the combinational strobe, keeping it out of the flops' data path.
  assign o_grant         = (i_reset && take) ? N_REQ'(1) << winner : '0;
  assign o_valid         = state_q == ST_FULL;
  assign o_data          = data_q;
  assign o_select        = sel_q;
  mux4 #(.NB(NB)) u_mux4 (
    .i_select (winner),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_c      (i_c),
    .i_d      (i_d),
    .o_data   (mux_out)
  );
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else if (take) begin
      state_q <= ST_FULL;
      data_q  <= mux_out;
      sel_q   <= winner;
      ptr_q   <= winner + NB_SELECT'(1);
    end else if (state_q == ST_FULL && i_ready) begin
      state_q <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: scoreboard bench for the round-robin arbiter
module tb_mux4_arbiter;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic [3:0]  i_req   = '0;
  logic [31:0] i_a = 32'd1, i_b = 32'd80, i_c = 32'd250, i_d = 32'd999;
  logic        i_ready = 1'b1;
  logic [3:0]  o_grant;
  logic [31:0] o_data;
  logic [1:0]  o_select;
  logic        o_valid;
  int checks = 0;
  int errors = 0;
  logic [33:0] sb_q[$];
  logic [1:0]  m_ptr   = '0;
  logic        m_valid = 1'b0;

  mux4_arbiter dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_req    (i_req),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_c      (i_c),
    .i_d      (i_d),
    .i_ready  (i_ready),
    .o_grant  (o_grant),
    .o_data   (o_data),
    .o_select (o_select),
    .o_valid  (o_valid)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model and scoreboard: predicts grants, pushes granted words, pops on accept.
  always @(negedge i_clock) begin
    logic [3:0]  eg;
    logic [1:0]  wk;
    logic [1:0]  k;
    logic [33:0] e;
    logic [31:0] dv[4];
    dv = '{i_a, i_b, i_c, i_d};
    if (!i_reset) begin
      checks++;
      if (o_grant !== 4'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_reset: grant=%b valid=%b, required 0000/0", o_grant, o_valid);
      end
      sb_q.delete();
      m_ptr   = '0;
      m_valid = 1'b0;
    end else begin
      eg = '0;
      wk = '0;
      for (int j = 0; j < 4; j++) begin
        k = m_ptr + 2'(j);
        if (eg == 4'b0 && i_req[k] && (!m_valid || i_ready)) begin
          eg[k] = 1'b1;
          wk    = k;
        end
      end
      checks++;
      if (o_grant !== eg) begin
        errors++;
        $display("FAIL sb_grant: got %b, required %b", o_grant, eg);
      end
      checks++;
      if (o_valid !== m_valid) begin
        errors++;
        $display("FAIL sb_valid: got %b, required %b", o_valid, m_valid);
      end
      if (m_valid && i_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: accept with empty scoreboard, data=%0d", o_data);
        end else begin
          e = sb_q.pop_front();
          if ({o_select, o_data} !== e) begin
            errors++;
            $display("FAIL sb_word: got sel=%0d data=%0d, required sel=%0d data=%0d",
                     o_select, o_data, e[33:32], e[31:0]);
          end
        end
      end
      if (eg != 4'b0) begin
        sb_q.push_back({wk, dv[wk]});
        m_valid = 1'b1;
        m_ptr   = wk + 2'd1;
      end else if (i_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    i_req   = 4'b1111;
    i_ready = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'd0 || o_select !== 2'd0 || o_grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d sel=%0d grant=%b, required 0/0/0/0000",
               o_valid, o_data, o_select, o_grant);
    end
    cyc();
    i_reset = 1'b1;
  endtask

  task automatic test_rotation();
    int exp_d[4] = '{1, 80, 250, 999};
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clock);
      if (i < 5) begin
        checks++;
        if (o_grant !== 4'(1 << (i % 4))) begin
          errors++;
          $display("FAIL rotation_grant[%0d]: got %b, required %b", i, o_grant, 4'(1 << (i % 4)));
        end
      end
      if (i > 0) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'(exp_d[(i - 1) % 4])) begin
          errors++;
          $display("FAIL rotation_data[%0d]: valid=%b data=%0d, required 1/%0d", i, o_valid, o_data, exp_d[(i - 1) % 4]);
        end
      end
      cyc();
      if (i == 4) i_req = '0;
    end
    cyc();
  endtask

  task automatic test_skip();
    i_req = 4'b0100;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL skip_g2: got %b, required 0100", o_grant);
    end
    cyc();
    i_req = 4'b1001;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b1000 || o_data !== 32'd250) begin
      errors++;
      $display("FAIL skip_g3: grant=%b data=%0d, required 1000/250", o_grant, o_data);
    end
    cyc();
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b0001 || o_data !== 32'd999) begin
      errors++;
      $display("FAIL skip_g0: grant=%b data=%0d, required 0001/999", o_grant, o_data);
    end
    cyc();
    i_req = '0;
    @(negedge i_clock);
    checks++;
    if (o_data !== 32'd1 || o_select !== 2'd0) begin
      errors++;
      $display("FAIL skip_word0: data=%0d sel=%0d, required 1/0", o_data, o_select);
    end
    cyc();
  endtask

  task automatic test_single();
    i_req = 4'b0010;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b, required 0010", o_grant);
    end
    cyc();
    i_req = '0;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd80 || o_select !== 2'd1) begin
      errors++;
      $display("FAIL single_word: valid=%b data=%0d sel=%0d, required 1/80/1", o_valid, o_data, o_select);
    end
    cyc();
  endtask

  task automatic test_stall();
    i_ready = 1'b0;
    i_req   = 4'b1111;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL stall_first: got %b, required 0100", o_grant);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clock);
      checks++;
      if (o_grant !== 4'b0 || o_valid !== 1'b1 || o_data !== 32'd250) begin
        errors++;
        $display("FAIL stall_hold[%0d]: grant=%b valid=%b data=%0d, required 0000/1/250", i, o_grant, o_valid, o_data);
      end
      cyc();
    end
    i_ready = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b1000) begin
      errors++;
      $display("FAIL stall_release: got %b, required 1000", o_grant);
    end
    cyc();
    i_req = '0;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd999) begin
      errors++;
      $display("FAIL stall_nobubble: valid=%b data=%0d, required 1/999", o_valid, o_data);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    i_req   = 4'b1111;
    i_ready = 1'b0;
    cyc();
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'd0 || o_grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%0d grant=%b, required 0/0/0000", o_valid, o_data, o_grant);
    end
    cyc();
    i_reset = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ptr: got %b, required 0001", o_grant);
    end
    cyc();
    i_req = '0;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd1) begin
      errors++;
      $display("FAIL reset_first_word: valid=%b data=%0d, required 1/1", o_valid, o_data);
    end
    cyc();
  endtask

  task automatic test_idle();
    i_req = '0;
    for (int i = 0; i < 6; i++) begin
      i_ready = i[0];
      @(negedge i_clock);
      checks++;
      if (o_grant !== 4'b0 || o_valid !== 1'b0 || o_data !== 32'd1 || o_select !== 2'd0) begin
        errors++;
        $display("FAIL idle[%0d]: grant=%b valid=%b data=%0d sel=%0d, required 0000/0/1/0",
                 i, o_grant, o_valid, o_data, o_select);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip();
    test_single();
    test_stall();
    test_reset_mid();
    test_idle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d words never delivered, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
